// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//
// Program-counter unit for a multicycle RISC-V style core. The PC advances
// only in the control FSM's update state and only when not stalled. The next
// PC comes from one of several sources: sequential, branch, jal, jalr or mret.
// A target that is not 4-byte aligned does not get loaded. Instead the unit
// redirects to a fixed trap vector, saves the faulting PC in epc, and raises
// a one-cycle misaligned pulse.
//
// Parameters
//   XLEN         width of PC, operands and counters
//   IMM_W        width of the signed byte-offset immediate
//   STATE_W      width of the control-FSM state input
//   UPDATE_STATE estado value in which the PC updates
//   RESET_PC     PC value after reset
//   TRAP_VEC     PC loaded on a misaligned-target trap
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   estado       current state of the multicycle control FSM
//   pcsrc        next-PC select: 0 seq, 1 branch, 2 jal, 3 jalr, 4 mret,
//                5-7 behave as seq
//   branch_taken branch condition result (used only for pcsrc=1)
//   immediate    signed byte offset
//   rs1_val      jalr base register value
//   stall        suppresses any update when 1
//   pc           registered current PC
//   pc_plus4     combinational pc+4 (link value)
//   epc          registered PC of the last trapping instruction
//   misaligned   registered one-cycle pulse on trap entry
//   instret      registered count of committed PC updates
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int                   XLEN         = 32,
    parameter int                   IMM_W        = 13,
    parameter int                   STATE_W      = 4,
    parameter logic [STATE_W-1:0]   UPDATE_STATE = 4'b1000,
    parameter logic [XLEN-1:0]      RESET_PC     = '0,
    parameter logic [XLEN-1:0]      TRAP_VEC     = 32'h100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] estado,
    input  logic [2:0]         pcsrc,
    input  logic               branch_taken,
    input  logic [IMM_W-1:0]   immediate,
    input  logic [XLEN-1:0]    rs1_val,
    input  logic               stall,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4,
    output logic [XLEN-1:0]    epc,
    output logic               misaligned,
    output logic [XLEN-1:0]    instret
);

    typedef enum logic [2:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JAL    = 3'd2,
        SRC_JALR   = 3'd3,
        SRC_MRET   = 3'd4
    } pcSrc_t;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_instret;
    logic            r_misaligned;

    logic [XLEN-1:0] w_immExt;
    logic [XLEN-1:0] w_seqTarget;
    logic [XLEN-1:0] w_relTarget;
    logic [XLEN-1:0] w_jalrSum;
    logic [XLEN-1:0] w_target;
    logic            w_update;
    logic            w_targetMisaligned;

    // Sign-extend the immediate so that negative offsets subtract correctly.
    // All sums below wrap naturally at XLEN bits.
    assign w_immExt    = {{(XLEN-IMM_W){immediate[IMM_W-1]}}, immediate};
    assign w_seqTarget = r_pc + XLEN'(4);
    assign w_relTarget = r_pc + w_immExt;
    assign w_jalrSum   = rs1_val + w_immExt;

    assign w_update = (estado == UPDATE_STATE) && !stall;

    // Next-PC selection. Reserved codes fall into the default and behave as
    // sequential. jalr clears only bit 0, so a base+offset with bit 1 set
    // still produces a misaligned target and traps.
    always_comb begin
        w_target = w_seqTarget;
        case (pcsrc)
            SRC_SEQ:    w_target = w_seqTarget;
            SRC_BRANCH: w_target = branch_taken ? w_relTarget : w_seqTarget;
            SRC_JAL:    w_target = w_relTarget;
            SRC_JALR:   w_target = {w_jalrSum[XLEN-1:1], 1'b0};
            SRC_MRET:   w_target = r_epc;
            default:    w_target = w_seqTarget;
        endcase
    end

    assign w_targetMisaligned = (w_target[1:0] != 2'b00);

    // State update. Reset wins over any update in the same cycle. The
    // misaligned pulse defaults low each cycle and is set only by a trapping
    // update, so it lasts exactly the cycle after the trap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_epc        <= '0;
            r_instret    <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            if (w_update) begin
                r_instret <= r_instret + XLEN'(1);
                if (w_targetMisaligned) begin
                    r_pc         <= TRAP_VEC;
                    r_epc        <= r_pc;
                    r_misaligned <= 1'b1;
                end else begin
                    r_pc <= w_target;
                end
            end
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = w_seqTarget;
    assign epc        = r_epc;
    assign misaligned = r_misaligned;
    assign instret    = r_instret;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//
// Directed testbench for pc_unit. It applies a linear sequence of steps, and
// each step is followed by checks against hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam int         XLEN    = 32;
    localparam int         IMM_W   = 13;
    localparam int         STATE_W = 4;
    localparam logic [3:0] UPD     = 4'b1000;
    localparam logic [3:0] IDLE    = 4'b0001;

    logic               clk;
    logic               rst_n;
    logic [STATE_W-1:0] estado;
    logic [2:0]         pcsrc;
    logic               branch_taken;
    logic [IMM_W-1:0]   immediate;
    logic [XLEN-1:0]    rs1_val;
    logic               stall;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    epc;
    logic               misaligned;
    logic [XLEN-1:0]    instret;

    int assertCount = 0;
    int failCount   = 0;

    pc_unit #(
        .XLEN         (XLEN),
        .IMM_W        (IMM_W),
        .STATE_W      (STATE_W),
        .UPDATE_STATE (UPD),
        .RESET_PC     (32'h0),
        .TRAP_VEC     (32'h100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .estado       (estado),
        .pcsrc        (pcsrc),
        .branch_taken (branch_taken),
        .immediate    (immediate),
        .rs1_val      (rs1_val),
        .stall        (stall),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .epc          (epc),
        .misaligned   (misaligned),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sets up the inputs and then waits for the given number of rising
    // edges. It returns 1 time unit after the last edge, so outputs are
    // sampled away from the edge.
    task automatic applyStimulus(input logic r, input logic [3:0] st,
                                 input logic [2:0] src, input logic bt,
                                 input logic [IMM_W-1:0] imm,
                                 input logic [XLEN-1:0] rs1,
                                 input logic stl, input int cycles);
        rst_n        = r;
        estado       = st;
        pcsrc        = src;
        branch_taken = bt;
        immediate    = imm;
        rs1_val      = rs1;
        stall        = stl;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compares one observed value against its expected value and keeps the
    // assertion and failure counts up to date.
    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset
        applyStimulus(1'b0, IDLE, 3'd0, 1'b0, 13'h0, 32'h0, 1'b0, 2);
        checkOutput("reset_pc",         pc,                32'h0);
        checkOutput("reset_epc",        epc,               32'h0);
        checkOutput("reset_instret",    instret,           32'h0);
        checkOutput("reset_misaligned", 32'(misaligned),   32'h0);
        checkOutput("reset_pc_plus4",   pc_plus4,          32'h4);

        // Three sequential updates
        applyStimulus(1'b1, UPD, 3'd0, 1'b0, 13'h0, 32'h0, 1'b0, 1);
        checkOutput("seq1_pc", pc, 32'h4);
        applyStimulus(1'b1, UPD, 3'd0, 1'b0, 13'h0, 32'h0, 1'b0, 1);
        checkOutput("seq2_pc", pc, 32'h8);
        applyStimulus(1'b1, UPD, 3'd0, 1'b0, 13'h0, 32'h0, 1'b0, 1);
        checkOutput("seq3_pc",       pc,       32'hC);
        checkOutput("seq3_instret",  instret,  32'd3);
        checkOutput("seq3_pc_plus4", pc_plus4, 32'h10);

        // Stall holds, and so does a non-update state
        applyStimulus(1'b1, UPD, 3'd0, 1'b0, 13'h0, 32'h0, 1'b1, 5);
        checkOutput("stall_pc",      pc,      32'hC);
        checkOutput("stall_instret", instret, 32'd3);
        applyStimulus(1'b1, IDLE, 3'd0, 1'b0, 13'h0, 32'h0, 1'b0, 5);
        checkOutput("idle_pc",      pc,      32'hC);
        checkOutput("idle_instret", instret, 32'd3);

        // jal +0x14 reaches 0x20, then a taken branch of -8 gives 0x18
        applyStimulus(1'b1, UPD, 3'd2, 1'b0, 13'h0014, 32'h0, 1'b0, 1);
        checkOutput("jal_pc", pc, 32'h20);
        applyStimulus(1'b1, UPD, 3'd1, 1'b1, 13'h1FF8, 32'hDEAD_BEE3, 1'b0, 1);
        checkOutput("br_taken_pc", pc, 32'h18);

        // jal +8 returns to 0x20, then a not-taken branch gives 0x24
        applyStimulus(1'b1, UPD, 3'd2, 1'b0, 13'h0008, 32'h0, 1'b0, 1);
        checkOutput("jal2_pc", pc, 32'h20);
        applyStimulus(1'b1, UPD, 3'd1, 1'b0, 13'h1FF8, 32'h0, 1'b0, 1);
        checkOutput("br_not_taken_pc", pc,      32'h24);
        checkOutput("br_instret",      instret, 32'd7);

        // jal +0x1C reaches 0x40, then jalr 0x1001 clears bit 0
        applyStimulus(1'b1, UPD, 3'd2, 1'b1, 13'h001C, 32'h0, 1'b0, 1);
        checkOutput("jal3_pc", pc, 32'h40);
        applyStimulus(1'b1, UPD, 3'd3, 1'b0, 13'h0000, 32'h1001, 1'b0, 1);
        checkOutput("jalr_pc", pc, 32'h1000);

        // jal -0xFC0 returns to 0x40, then jalr 0x1002 traps
        applyStimulus(1'b1, UPD, 3'd2, 1'b0, 13'h1040, 32'h0, 1'b0, 1);
        checkOutput("jal_back_pc", pc, 32'h40);
        applyStimulus(1'b1, UPD, 3'd3, 1'b0, 13'h0000, 32'h1002, 1'b0, 1);
        checkOutput("trap_pc",         pc,              32'h100);
        checkOutput("trap_epc",        epc,             32'h40);
        checkOutput("trap_misaligned", 32'(misaligned), 32'h1);
        checkOutput("trap_instret",    instret,         32'd11);

        // The misaligned pulse drops after one cycle
        applyStimulus(1'b1, IDLE, 3'd0, 1'b0, 13'h0, 32'h0, 1'b0, 1);
        checkOutput("pulse_end",  32'(misaligned), 32'h0);
        checkOutput("hold_trap_pc", pc,            32'h100);

        // mret returns to epc
        applyStimulus(1'b1, UPD, 3'd4, 1'b1, 13'h0004, 32'h3, 1'b0, 1);
        checkOutput("mret_pc",         pc,              32'h40);
        checkOutput("mret_epc",        epc,             32'h40);
        checkOutput("mret_misaligned", 32'(misaligned), 32'h0);
        checkOutput("mret_instret",    instret,         32'd12);

        // Wrap from 0xFFFFFFFC to 0
        applyStimulus(1'b1, UPD, 3'd3, 1'b0, 13'h0000, 32'hFFFF_FFFC, 1'b0, 1);
        checkOutput("wrap_pre_pc",     pc,       32'hFFFF_FFFC);
        checkOutput("wrap_pre_plus4",  pc_plus4, 32'h0);
        applyStimulus(1'b1, UPD, 3'd0, 1'b0, 13'h0000, 32'h0, 1'b0, 1);
        checkOutput("wrap_pc", pc, 32'h0);

        // A reserved code behaves as seq, then jal +2 traps
        applyStimulus(1'b1, UPD, 3'd5, 1'b1, 13'h0002, 32'h1001, 1'b0, 1);
        checkOutput("reserved_pc", pc, 32'h4);
        applyStimulus(1'b1, UPD, 3'd2, 1'b0, 13'h0002, 32'h0, 1'b0, 1);
        checkOutput("jal_trap_pc",  pc,      32'h100);
        checkOutput("jal_trap_epc", epc,     32'h4);
        checkOutput("jal_trap_ins", instret, 32'd16);

        // Reset during an update cycle discards the update
        applyStimulus(1'b0, UPD, 3'd0, 1'b0, 13'h0, 32'h0, 1'b0, 1);
        checkOutput("rst_upd_pc",         pc,              32'h0);
        checkOutput("rst_upd_instret",    instret,         32'h0);
        checkOutput("rst_upd_epc",        epc,             32'h0);
        checkOutput("rst_upd_misaligned", 32'(misaligned), 32'h0);

        // The first update after reset has no extra latency
        applyStimulus(1'b1, UPD, 3'd0, 1'b0, 13'h0, 32'h0, 1'b0, 1);
        checkOutput("post_rst_pc",      pc,      32'h4);
        checkOutput("post_rst_instret", instret, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, meaning: width of PC, operands and counters.
REQ-002 Parameter IMM_W, default 13, meaning: width of the signed byte-offset immediate.
REQ-003 Parameter STATE_W, default 4, meaning: width of the control-FSM state input.
REQ-004 Parameter UPDATE_STATE, default 4'b1000, meaning: estado value in which PC updates.
REQ-005 Parameter RESET_PC, default 0, meaning: PC value after reset.
REQ-006 Parameter TRAP_VEC, default 32'h100, meaning: PC loaded on misaligned-target trap.
REQ-007 Port: clk, input, 1, meaning: sole clock; all state updates on rising edge.
REQ-008 Port: rst_n, input, 1, meaning: synchronous active-low reset, sampled on rising clk.
REQ-009 Port: estado, input, STATE_W, meaning: current state of the multicycle control FSM.
REQ-010 Port: pcsrc, input, 3, meaning: next-PC select; 0 seq, 1 branch, 2 jal, 3 jalr, 4 mret, 5-7 reserved.
REQ-011 Port: branch_taken, input, 1, meaning: branch condition result, used only when pcsrc=1.
REQ-012 Port: immediate, input, IMM_W, meaning: signed two's-complement byte offset.
REQ-013 Port: rs1_val, input, XLEN, meaning: base register value for jalr.
REQ-014 Port: stall, input, 1, meaning: when 1, suppresses any update.
REQ-015 Port: pc, output, XLEN, meaning: registered current PC (byte address).
REQ-016 Port: pc_plus4, output, XLEN, meaning: combinational pc+4 (link value).
REQ-017 Port: epc, output, XLEN, meaning: registered PC of the last trapping instruction.
REQ-018 Port: misaligned, output, 1, meaning: registered one-cycle pulse on trap entry.
REQ-019 Port: instret, output, XLEN, meaning: registered count of committed PC updates.

Function
REQ-020 An update occurs on a rising edge iff rst_n=1, estado==UPDATE_STATE and stall=0; otherwise pc, epc and instret hold.
REQ-021 Immediate is sign-extended from IMM_W to XLEN before any addition.
REQ-022 Candidate target: seq -> pc+4; branch -> pc+imm if branch_taken else pc+4; jal -> pc+imm; jalr -> (rs1_val+imm) with bit 0 cleared; mret -> epc.
REQ-023 Reserved pcsrc codes 5-7 are treated as seq.
REQ-024 All additions wrap modulo 2^XLEN; no overflow flag.
REQ-025 If candidate target bits [1:0] != 0 on an update, pc <= TRAP_VEC, epc <= current pc, and misaligned = 1 for exactly the following cycle.
REQ-026 A misaligned mret target (epc[1:0] != 0) also traps per REQ-025, overwriting epc with the current pc.
REQ-027 On an aligned update, pc <= target and epc holds.
REQ-028 misaligned is 0 in every cycle not immediately following a trapping update.
REQ-029 instret increments by 1 on every update, including trapping updates, and wraps from all-ones to 0.
REQ-030 pc_plus4 equals pc+4 modulo 2^XLEN at all times, including during reset and stall.
REQ-031 Unused inputs (branch_taken, rs1_val) in a given mode have no effect.

Reset
REQ-032 When rst_n=0 at a rising edge: pc <= RESET_PC, epc <= 0, instret <= 0, misaligned <= 0, regardless of estado, stall or pcsrc.
REQ-033 Reset has priority over any simultaneous update; asserting reset during an UPDATE_STATE cycle discards that update.
REQ-034 After rst_n returns to 1, the first update follows REQ-020 with no extra latency.

Verification
REQ-035 Reset, then 3 updates with pcsrc=0 -> pc = 0x0, 0x4, 0x8, 0xC; instret = 3; pc_plus4 = 0x10.
REQ-036 pc=0x20, pcsrc=1, imm=-8, branch_taken=1 -> pc=0x18; same with branch_taken=0 -> pc=0x24.
REQ-037 pc=0x40, pcsrc=3, rs1_val=0x1001, imm=0 -> pc=0x1000 (bit 0 cleared); rs1_val=0x1002 -> pc=0x100, epc=0x40, misaligned=1 for one cycle.
REQ-038 pcsrc=0 with stall=1, or with estado != UPDATE_STATE, for 5 cycles -> pc and instret unchanged; pc=0xFFFFFFFC with seq update -> pc=0x0.
REQ-039 Trap from pc=0x40, then pcsrc=4 at pc=0x100 -> pc=0x40; rst_n=0 coincident with an update -> pc=RESET_PC, instret=0.
